// File: rtl/stf_seq_gen.sv
// rtl/stf_seq_gen.sv - STF sequencer: walks the 16-entry STF ROM REPS times onto a valid/ready stream
module stf_seq_gen #(
  parameter int REPS      = 10,
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        phy_tx_arest,
  input  logic        start,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int N  = REPS * 16;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic [31:0]   windowed;
  logic          accept;

  // Half-amplitude first sample: arithmetic shift of each component keeps the sign
  assign windowed = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
  assign accept   = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave RUN only once the final sample has been taken downstream
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && (idx == LAST_IDX)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: in RUN the ROM is pre-addressed with the next sample
  always_comb begin
    rom_addr = 4'd0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_RUN: begin
        rom_addr = idx[3:0] + 4'd1;
        busy     = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        rom_addr = 4'd0;
      end
    endcase
  end

  // Sample datapath: load on start, advance on each handshake, hold while stalled
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      idx       <= '0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            out_data  <= WINDOW_EN ? windowed : rom_dout;
            idx       <= '0;
            out_valid <= 1'b1;
            out_last  <= (N == 1);
          end
        end
        S_RUN: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx + IW'(1);
              out_data <= rom_dout;
              out_last <= ((idx + IW'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stf_seq_gen.md
Name: stf_seq_gen

Overview:
- Sequencer that drives the 16-entry STF sample ROM and streams the full 802.11a/g short training field (REPS × 16 samples, default 160) to the TX sample mux.
- Each ROM word is {I[31:16], Q[15:0]}, signed 16-bit per component.
- Sits between the TX control FSM (start/done) and the downstream sample mux (valid/ready stream). Applies the optional half-amplitude window to the first sample.

Parameters:
REPS, 10, number of 16-sample STF periods emitted; legal range 1..16.
WINDOW_EN, 1, 1 = halve sample 0 (per-component arithmetic shift right by 1); 0 = sample 0 passed unmodified.

Ports:
clk  in  1  system clock
phy_tx_arest  in  1  asynchronous active-high reset
start  in  1  single-cycle request to emit one STF; honoured only in IDLE
rom_addr  out  4  address to STF ROM (combinational ROM, zero latency)
rom_dout  in  32  ROM sample {I,Q}
out_data  out  32  registered sample {I,Q}
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  downstream accepts the sample when out_valid && out_ready
out_last  out  1  high with the final sample (index REPS*16-1)
busy  out  1  high in RUN and DONE
done  out  1  single-cycle pulse after the last sample is accepted

Behaviour:
- Reset, asynchronous: state=IDLE, idx=0, out_data=0, out_valid=0, out_last=0, done=0.
- Sample counter idx is wide enough for REPS*16-1 (8 bits at default). N = REPS*16.
- rom_addr, combinational: 0 in IDLE; (idx+1) mod 16 in RUN; 0 in DONE.
- IDLE:
  - On start: out_data<=window(rom_dout); idx<=0; out_valid<=1; out_last<=(N==1); go to RUN.
  - First valid sample therefore appears the cycle after start.
- window(x): if WINDOW_EN, each 16-bit component is arithmetic-shifted right by 1 (sign preserved, round toward −inf). Applied to sample idx 0 only.
- RUN, handshake (out_valid && out_ready):
  - If idx==N-1: out_valid<=0; out_last<=0; go to DONE.
  - Else: idx<=idx+1; out_data<=rom_dout, which is the ROM word at (idx+1) mod 16 with no window; out_last<=(idx+1==N-1).
- RUN, no handshake: out_data, out_valid, out_last and idx hold. Stream rule: once asserted, valid is never withdrawn before acceptance.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays high through DONE.
- start is ignored in RUN and DONE; there is no queuing. A start in the same cycle as the return to IDLE is ignored; a start in the first IDLE cycle is accepted.
- Throughput: with out_ready held high, one sample per cycle. Total run is 1 (start) + N samples + 1 (DONE) cycles.
- Reset asserted mid-run: immediate abort to reset values. No done pulse, no partial-frame recovery.
- Sample index wrap: ROM address wraps modulo 16; the period repeats exactly REPS times.

Test Plan:
1. Reset, then a start pulse with out_ready=1, WINDOW_EN=1 -> out_valid rises next cycle. Samples 0..3 = fe87_fe87, fbd6_0000, fd0e_02f2, 0000_042a. Exactly 160 handshakes. Sample 159 = 0000_fbd6 with out_last=1. done pulses once, one cycle after sample 159 is accepted.
2. WINDOW_EN=0 -> sample 0 = fd0e_fd0e. Samples 16 and 144 = fd0e_fd0e. Samples 4 and 12 = 02f2_02f2. No other difference from scenario 1.
3. Backpressure: out_ready toggles randomly (about 50%) -> out_data/out_last stable while stalled. Sequence identical to scenario 1. Exactly 160 accepts. done after the last accept.
4. Start pulses during RUN at samples 5 and 159, and during DONE -> ignored. Exactly one STF of 160 samples. busy high from the cycle after start through the DONE cycle.
5. Assert phy_tx_arest at sample 70 -> all outputs 0 on the same edge, no done. A subsequent start yields a full fresh 160-sample STF beginning with fe87_fe87.
6. REPS=1 -> 16 samples. out_last asserted on sample 15 (0000_fbd6). done pulses. A start in the first IDLE cycle after DONE launches a second STF.
